// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl
//   Adds two W*NCHUNK-bit operands by time-sharing one external W-bit
//   carry-lookahead adder slice. Operands are latched on an accepted start,
//   then one chunk per cycle is presented to the CLA, least-significant chunk
//   first, with the chunk carry-out registered and fed back as the next
//   chunk's carry-in.
//
// Ports
//   clk          rising-edge clock
//   sync_reset_n synchronous active-low reset
//   start        request pulse, only sampled in IDLE
//   a, b, cin    operands and initial carry, latched on accepted start
//   busy         high while chunks are being processed (RUN)
//   done         one-cycle pulse, sum/cout valid
//   sum, cout    registered full-width result and final carry
//   cla_a/b/cin  chunk operands and carry presented to the shared CLA
//   cla_sum/cout combinational result returned by the shared CLA
module cla_seq_ctrl #(
    parameter int W      = 4,
    parameter int NCHUNK = 4
) (
    input  logic                  clk,
    input  logic                  sync_reset_n,
    input  logic                  start,
    input  logic [W*NCHUNK-1:0]   a,
    input  logic [W*NCHUNK-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [W*NCHUNK-1:0]   sum,
    output logic                  cout,
    output logic [W-1:0]          cla_a,
    output logic [W-1:0]          cla_b,
    output logic                  cla_cin,
    input  logic [W-1:0]          cla_sum,
    input  logic                  cla_cout
);

    localparam int OW = W * NCHUNK;
    // A single-chunk configuration still needs a one-bit index register.
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   a_reg_q, a_reg_d;
    logic [OW-1:0]   b_reg_q, b_reg_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [OW-1:0]   sum_q, sum_d;
    logic            cout_q, cout_d;

    always_comb begin
        state_d = state_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_reg_d = a;
                    b_reg_d = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // CLA inputs come from registers only, so the critical path
                // is carry_q -> CLA -> carry_q.
                cla_cin = carry_q;
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IW'(k)) begin
                        cla_a              = a_reg_q[k*W +: W];
                        cla_b              = b_reg_q[k*W +: W];
                        sum_d[k*W +: W]    = cla_sum;
                    end
                end
                carry_d = cla_cout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = cla_cout;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // start is deliberately not queued here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand copies are never observed outside RUN, so they are not reset.
    always_ff @(posedge clk) begin
        a_reg_q <= a_reg_d;
        b_reg_q <= b_reg_d;
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q <= S_IDLE;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Testbench for cla_seq_ctrl with W=4, NCHUNK=4. A behavioural CLA slice
// closes the loop; expected results are hand-computed in the vector table.
module tb_cla_seq_ctrl;

    localparam int W      = 4;
    localparam int NCHUNK = 4;

    logic          clk = 1'b0;
    logic          sync_reset_n;
    logic          start;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [15:0]   sum;
    logic          cout;
    logic [3:0]    cla_a;
    logic [3:0]    cla_b;
    logic          cla_cin;
    logic [3:0]    cla_sum;
    logic          cla_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared combinational adder slice.
    assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0000, cla_cin};

    cla_seq_ctrl #(
        .W      (W),
        .NCHUNK (NCHUNK)
    ) dut (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .start        (start),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .busy         (busy),
        .done         (done),
        .sum          (sum),
        .cout         (cout),
        .cla_a        (cla_a),
        .cla_b        (cla_b),
        .cla_cin      (cla_cin),
        .cla_sum      (cla_sum),
        .cla_cout     (cla_cout)
    );

    // cc bit k is the carry presented to the CLA while chunk k is processed.
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic [3:0]  cc;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one operation and follow it cycle by cycle through RUN and DONE.
    task automatic run_vec(input int i);
        @(negedge clk);
        a     = vecs[i].a;
        b     = vecs[i].b;
        cin   = vecs[i].cin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: only the latched copies may matter.
        a     = ~vecs[i].a;
        b     = ~vecs[i].b;
        cin   = ~vecs[i].cin;
        for (int k = 0; k < NCHUNK; k++) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("cla_a", 32'(cla_a), 32'((vecs[i].a >> (4*k)) & 16'h000F));
            check("cla_b", 32'(cla_b), 32'((vecs[i].b >> (4*k)) & 16'h000F));
            check("cla_cin", 32'(cla_cin), 32'(vecs[i].cc[k]));
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(vecs[i].sum));
        check("cout", 32'(cout), 32'(vecs[i].cout));
        check("done_cla_a", 32'(cla_a), 32'd0);
        @(negedge clk);
        check("after_done", 32'(done), 32'd0);
        check("after_busy", 32'(busy), 32'd0);
        check("sum_hold", 32'(sum), 32'(vecs[i].sum));
        check("cout_hold", 32'(cout), 32'(vecs[i].cout));
    endtask

    initial begin
        vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, cout: 1'b0, cc: 4'b0000};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, cc: 4'b1110};
        vecs[2] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sum: 16'h0000, cout: 1'b1, cc: 4'b1111};
        vecs[3] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, sum: 16'h0001, cout: 1'b0, cc: 4'b0001};
        vecs[4] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, cc: 4'b0000};
        vecs[5] = '{a: 16'hABCD, b: 16'h1111, cin: 1'b0, sum: 16'hBCDE, cout: 1'b0, cc: 4'b0000};
        vecs[6] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1, cc: 4'b1111};
        vecs[7] = '{a: 16'h0FF0, b: 16'h0010, cin: 1'b0, sum: 16'h1000, cout: 1'b0, cc: 4'b1100};

        // Reset held with start asserted.
        sync_reset_n = 1'b0;
        start        = 1'b1;
        a            = 16'h1234;
        b            = 16'h4321;
        cin          = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_cla_a", 32'(cla_a), 32'd0);
        check("rst_cla_b", 32'(cla_b), 32'd0);
        check("rst_cla_cin", 32'(cla_cin), 32'd0);
        sync_reset_n = 1'b1;
        start        = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Table-driven operations.
        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // Start while busy and while in DONE is dropped.
        @(negedge clk);
        a     = 16'h1234;
        b     = 16'h4321;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("sb_cla_a0", 32'(cla_a), 32'h4);
        @(negedge clk);
        check("sb_cla_a1", 32'(cla_a), 32'h3);
        a     = 16'h1111;
        b     = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("sb_cla_a2", 32'(cla_a), 32'h2);
        check("sb_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("sb_cla_a3", 32'(cla_a), 32'h1);
        @(negedge clk);
        check("sb_done", 32'(done), 32'd1);
        check("sb_sum", 32'(sum), 32'h5555);
        check("sb_cout", 32'(cout), 32'd0);
        start = 1'b1;
        @(negedge clk);
        check("sb_drop_in_done", 32'(busy), 32'd0);
        check("sb_idle_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("sb_accept_busy", 32'(busy), 32'd1);
        check("sb_accept_cla_a", 32'(cla_a), 32'h1);
        repeat (4) @(negedge clk);
        check("sb2_done", 32'(done), 32'd1);
        check("sb2_sum", 32'(sum), 32'h1111);
        check("sb2_cout", 32'(cout), 32'd0);

        // Reset in the middle of a run.
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mr_busy_before", 32'(busy), 32'd1);
        sync_reset_n = 1'b0;
        @(negedge clk);
        sync_reset_n = 1'b1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_sum", 32'(sum), 32'd0);
        check("mr_cout", 32'(cout), 32'd0);
        check("mr_cla_cin", 32'(cla_cin), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("mr_no_done", 32'(done), 32'd0);
            check("mr_idle", 32'(busy), 32'd0);
        end
        run_vec(0);
        run_vec(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
